// File: rtl/pattern_scan_arbiter.sv
// Shares one serial pattern-detector lane among N_REQ requesters: grant, clear, shift MSB-first, count hits, respond.
// Define PSCAN_FIXED_PRIO_EN for fixed lowest-index-wins arbitration (no round-robin pointer register).
module pattern_scan_arbiter #(
   parameter int  N_REQ   = 4,
   parameter int  DATA_W  = 16,
   parameter int  DET_LAT = 1,
   localparam int ID_W    = $clog2(N_REQ),
   localparam int CNT_W   = $clog2(DATA_W + 1)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      det_clr,
   output logic                      det_en,
   output logic                      det_bit,
   input  logic                      det_hit,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [CNT_W-1:0]          rsp_count,
   input  logic                      rsp_ready,
   output logic                      busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_CLR   = 3'd2,
      S_SHIFT = 3'd3,
      S_DRAIN = 3'd4,
      S_RESP  = 3'd5
   } state_e;

   localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1'b1);

   state_e             state_q;
   logic [N_REQ-1:0]   req_ready_q;
   logic               det_clr_q;
   logic               det_en_q;
   logic               det_bit_q;
   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [CNT_W-1:0]   rsp_count_q;
   logic               busy_q;
   logic [ID_W-1:0]    id_q;
   logic [DATA_W-1:0]  word_q;
   logic [CNT_W-1:0]   cyc_q;
   logic [CNT_W-1:0]   hit_cnt_q;
   logic [DET_LAT-1:0] en_pipe_q;
   logic [DET_LAT-1:0] en_next_s;
   logic               hit_smp_s;
   logic               win_any_s;
   logic [ID_W-1:0]    cand_s;
   logic [ID_W-1:0]    win_id_d;
`ifndef PSCAN_FIXED_PRIO_EN
   logic [ID_W-1:0]    ptr_q;
`endif

   assign req_ready = req_ready_q;
   assign det_clr   = det_clr_q;
   assign det_en    = det_en_q;
   assign det_bit   = det_bit_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_count = rsp_count_q;
   assign busy      = busy_q;

   // det_en delayed by DET_LAT marks the cycles whose det_hit belongs to the word
   if (DET_LAT == 1) begin : g_lat1
      assign en_next_s = det_en_q;
   end else begin : g_latn
      assign en_next_s = {en_pipe_q[DET_LAT-2:0], det_en_q};
   end
   assign hit_smp_s = en_pipe_q[DET_LAT-1] & det_hit;

   // Winner selection: scanning candidates from last to first lets the first set one win
   always_comb begin
      win_id_d  = ID_W'(0);
      cand_s    = ID_W'(0);
      win_any_s = |req_valid;
      for (int j = N_REQ - 1; j >= 0; j--) begin
`ifdef PSCAN_FIXED_PRIO_EN
         cand_s = ID_W'(j);
`else
         cand_s = ID_W'((int'(ptr_q) + j) % N_REQ);
`endif
         win_id_d = req_valid[cand_s] ? cand_s : win_id_d;
      end
   end

   // Transaction FSM with all outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         req_ready_q <= '0;
         det_clr_q   <= 1'b0;
         det_en_q    <= 1'b0;
         det_bit_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_count_q <= '0;
         busy_q      <= 1'b0;
         id_q        <= '0;
         word_q      <= '0;
         cyc_q       <= '0;
`ifndef PSCAN_FIXED_PRIO_EN
         ptr_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_any_s) begin
                  state_q     <= S_GRANT;
                  req_ready_q <= ONE_HOT_0 << win_id_d;
                  id_q        <= win_id_d;
                  busy_q      <= 1'b1;
               end else begin
                  busy_q      <= 1'b0;
               end
            end
            S_GRANT: begin
               req_ready_q <= '0;
               word_q      <= req_data[id_q*DATA_W +: DATA_W];
               det_clr_q   <= 1'b1;
               state_q     <= S_CLR;
`ifndef PSCAN_FIXED_PRIO_EN
               ptr_q       <= (id_q == ID_W'(N_REQ - 1)) ? ID_W'(0) : id_q + ID_W'(1);
`endif
            end
            S_CLR: begin
               det_clr_q <= 1'b0;
               det_en_q  <= 1'b1;
               det_bit_q <= word_q[DATA_W-1];
               word_q    <= {word_q[DATA_W-2:0], 1'b0};
               cyc_q     <= '0;
               state_q   <= S_SHIFT;
            end
            S_SHIFT: begin
               if (cyc_q == CNT_W'(DATA_W - 1)) begin
                  det_en_q  <= 1'b0;
                  det_bit_q <= 1'b0;
                  cyc_q     <= '0;
                  state_q   <= S_DRAIN;
               end else begin
                  det_bit_q <= word_q[DATA_W-1];
                  word_q    <= {word_q[DATA_W-2:0], 1'b0};
                  cyc_q     <= cyc_q + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               // the last window sample lands in this final drain cycle, so fold it in here
               if (cyc_q == CNT_W'(DET_LAT - 1)) begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_count_q <= hit_cnt_q + CNT_W'(hit_smp_s);
                  cyc_q       <= '0;
                  state_q     <= S_RESP;
               end else begin
                  cyc_q       <= cyc_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= '0;
               det_clr_q   <= 1'b0;
               det_en_q    <= 1'b0;
               det_bit_q   <= 1'b0;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // Hit window pipeline and hit counter, zeroed while the detector is cleared
   always_ff @(posedge clk) begin
      if (!rstn) begin
         en_pipe_q <= '0;
         hit_cnt_q <= '0;
      end else begin
         en_pipe_q <= en_next_s;
         if (state_q == S_CLR) begin
            hit_cnt_q <= '0;
         end else if (hit_smp_s) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
         end else begin
            hit_cnt_q <= hit_cnt_q;
         end
      end
   end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Bench for pattern_scan_arbiter: 1011 sliding-window detector (DET_LAT=1), directed and random transactions
// checked against a string-match hit model and a behavioural arbitration model.
module tb_pattern_scan_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic [N-1:0]  req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          det_clr;
   logic          det_en;
   logic          det_bit;
   logic          det_hit;
   logic          rsp_valid;
   logic [1:0]    rsp_id;
   logic [4:0]    rsp_count;
   logic          rsp_ready;
   logic          busy;

   int            n_pass = 0;
   int            n_fail = 0;
   int            n_total = 0;
   int            cyc = 0;
   int            rr_ptr = 0;
   int            t_grant = 0;
   int            last_hs = 0;
   logic          hs_valid = 1'b0;
   logic [W-1:0]  cur_word;

   logic [3:0]    det_win = 4'b0;
   logic          hit_r = 1'b0;
   logic          prev_en_r = 1'b0;
   logic          noise_on = 1'b1;

   pattern_scan_arbiter dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .det_clr   (det_clr),
      .det_en    (det_en),
      .det_bit   (det_bit),
      .det_hit   (det_hit),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_count (rsp_count),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Detector: 4-bit window over det_bit while det_en, hit on 1011 one cycle later
   always @(posedge clk) begin
      if (det_clr) begin
         det_win <= 4'b0;
         hit_r   <= 1'b0;
      end else if (det_en) begin
         det_win <= {det_win[2:0], det_bit};
         hit_r   <= ({det_win[2:0], det_bit} == 4'b1011);
      end else begin
         hit_r   <= 1'b0;
      end
      prev_en_r <= det_en;
   end

   // Spurious hits outside the counting window must be ignored by the DUT
   assign det_hit = hit_r | (noise_on & ~prev_en_r);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int count_hits(input logic [W-1:0] w);
      int c = 0;
      for (int p = W - 1; p >= 3; p--) begin
         if (w[p -: 4] == 4'b1011) c++;
      end
      return c;
   endfunction

   function automatic int model_winner(input logic [N-1:0] m);
`ifdef PSCAN_FIXED_PRIO_EN
      for (int o = 0; o < N; o++) if (m[o]) return o;
`else
      for (int o = 0; o < N; o++) if (m[(rr_ptr + o) % N]) return (rr_ptr + o) % N;
`endif
      return 0;
   endfunction

   task automatic grant_phase(input logic [N-1:0] mask, input logic use_word, input logic [W-1:0] word,
                              output int w);
      int n = 0;
      w = model_winner(mask);
      req_valid = mask;
      req_data  = {$urandom, $urandom};
      if (use_word) req_data[w*W +: W] = word;
      cur_word = req_data[w*W +: W];
      while (req_ready == 4'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("grant_wait", 64'(n < 40), 64'(1));
      t_grant = cyc;
      check("req_ready", 64'(req_ready), 64'(4'b0001 << w));
      check("busy_grant", 64'(busy), 64'(1));
      if (hs_valid) check("grant_gap", 64'(t_grant - last_hs), 64'(2));
      hs_valid = 1'b0;
      rr_ptr = (w + 1) % N;
   endtask

   task automatic finish_phase(input int w, input int exp_cnt, input int stall);
      logic [W-1:0] bits = '0;
      logic         all_en = 1'b1;
      logic [1:0]   wid = w[1:0];
      logic [4:0]   ecnt;
      int           n = 0;
      @(negedge clk);
      check("clr_cycle", 64'({req_ready, det_clr, det_en}), 64'({4'b0000, 1'b1, 1'b0}));
      req_data = {$urandom, $urandom};
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         bits[W-1-k] = det_bit;
         all_en = all_en & det_en;
      end
      check("shift_bits", 64'(bits), 64'(cur_word));
      check("shift_en", 64'(all_en), 64'(1));
      while (!rsp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("rsp_wait", 64'(n < 30), 64'(1));
      check("latency", 64'(cyc - t_grant), 64'(W + 3));
      ecnt = (exp_cnt < 0) ? 5'(count_hits(cur_word)) : 5'(exp_cnt);
      check("rsp_id", 64'(rsp_id), 64'(wid));
      check("rsp_count", 64'(rsp_count), 64'(ecnt));
      check("busy_rsp", 64'(busy), 64'(1));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("rsp_hold", 64'({rsp_valid, rsp_id, rsp_count, req_ready, busy}),
               64'({1'b1, wid, ecnt, 4'b0000, 1'b1}));
      end
      rsp_ready = 1'b1;
      last_hs = cyc;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_done", 64'({rsp_valid, busy}), 64'(2'b00));
      hs_valid = 1'b1;
   endtask

   initial begin
      int         w;
      logic       seen;
      logic [N-1:0] m;
      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({req_ready, det_clr, det_en, det_bit, rsp_valid, rsp_id, rsp_count, busy}), 64'(0));
      rstn = 1'b1;
      @(negedge clk);

      // Fairness: requesters 0,1,3 held for four transactions
      for (int t = 0; t < 4; t++) begin
         grant_phase(4'b1011, 1'b0, 16'h0000, w);
         finish_phase(w, -1, 0);
      end

      grant_phase(4'b0100, 1'b1, 16'hB000, w);
      finish_phase(w, 1, 0);
      grant_phase(4'b0001, 1'b1, 16'hBBBB, w);
      finish_phase(w, 4, 0);
      grant_phase(4'b0001, 1'b1, 16'h0000, w);
      finish_phase(w, 0, 0);
      grant_phase(4'b0001, 1'b1, 16'hFFFF, w);
      finish_phase(w, 0, 0);

      // Backpressure then an immediate follow-on grant
      grant_phase(4'b0110, 1'b0, 16'h0000, w);
      finish_phase(w, -1, 10);
      grant_phase(4'b1001, 1'b0, 16'h0000, w);
      finish_phase(w, -1, 0);

      req_valid = '0;
      hs_valid  = 1'b0;
      repeat (3) @(negedge clk);

      for (int t = 0; t < 12; t++) begin
         m = 4'($urandom_range(1, 15));
         grant_phase(m, 1'b0, 16'h0000, w);
         finish_phase(w, -1, $urandom_range(0, 3));
      end

      // Reset at shift cycle 5 of a transaction from requester 1
      grant_phase(4'b0010, 1'b0, 16'h0000, w);
      repeat (7) @(negedge clk);
      rstn      = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rstn = 1'b1;
      check("reset_mid_outputs", 64'({req_ready, det_clr, det_en, det_bit, rsp_valid, rsp_id, rsp_count, busy}), 64'(0));
      rr_ptr   = 0;
      hs_valid = 1'b0;
      seen     = 1'b0;
      repeat (25) begin
         @(negedge clk);
         seen = seen | rsp_valid | busy;
      end
      check("no_rsp_after_reset", 64'(seen), 64'(0));
      grant_phase(4'b1010, 1'b0, 16'h0000, w);
      finish_phase(w, -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
